// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: zero-latency lookup for fetch, trained from MEM.
// Optional BTB_STATS_EN adds saturating branch/mispredict counters (stat_branches, stat_mispredicts).
module btb_branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, mp_raw;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Outputs are forced to their fall-through values while reset is held.
  assign pred_taken  = nRST && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;

  assign mp_raw     = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));
  assign mispredict = nRST && mp_raw;
  assign correct_pc = (nRST && upd_taken) ? upd_target : upd_pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_ONE;
          target_q[up_idx] <= upd_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_ONE;
        end
      end else if (upd_taken) begin
        // A taken miss evicts whatever aliases at this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= WEAK_T;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_en && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mp_raw && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Scoreboard bench for btb_branch_predictor: directed cases then random traffic vs. an array-based model.
module tb_btb_branch_predictor;
  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int IDX_W    = $clog2(ENTRIES);
  localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF = 1 << (CTR_BITS - 1);

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] correct_pc;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  btb_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_pc(lookup_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .correct_pc(correct_pc)
`ifdef BTB_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ptk;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] cpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference table: one slot per index, plain integers for the counter.
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_br, m_mp;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = CTR_HALF - 1;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic step(input bit rst, input logic [31:0] lk, input bit en,
                      input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt);
    exp_t e;
    int   i;
    bit   mp;
    @(posedge CLK);
    #1;
    nRST = !rst; lookup_pc = lk; upd_en = en; upd_pc = pc; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    if (rst) model_reset();
    mp = en && ((tk != ptk) || (tk && tgt != ptgt));
    e.ptk  = rst ? 1'b0 : m_pred(lk);
    e.ptgt = rst ? lk + 32'd4 : m_ptgt(lk);
    e.mp   = rst ? 1'b0 : mp;
    e.cpc  = (!rst && tk) ? tgt : pc + 32'd4;
    e.sb   = 32'(m_br);
    e.sm   = 32'(m_mp);
    exp_q.push_back(e);
    if (!rst && en) begin
      i = idx_of(pc);
      if (m_hit(pc)) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
          m_target[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt; m_ctr[i] = CTR_HALF;
      end
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pred_taken", 32'(pred_taken), 32'(e.ptk));
        check("pred_target", pred_target, e.ptgt);
        check("mispredict", 32'(mispredict), 32'(e.mp));
        check("correct_pc", correct_pc, e.cpc);
`ifdef BTB_STATS_EN
        check("stat_branches", stat_branches, e.sb);
        check("stat_mispredicts", stat_mispredicts, e.sm);
`endif
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    return {$urandom_range(0, 2) << (IDX_W + 2)} | ($urandom_range(0, ENTRIES - 1) << 2)
           | $urandom_range(0, 3);
  endfunction

  task automatic rand_steps(input int n);
    logic [31:0] pc, lk, tgt, ptgt;
    bit en, tk, ptk;
    for (int k = 0; k < n; k++) begin
      pc   = rand_pc();
      lk   = ($urandom_range(0, 9) < 3) ? pc : rand_pc();
      en   = ($urandom_range(0, 9) < 8);
      tk   = $urandom_range(0, 1);
      tgt  = ($urandom_range(0, 3) == 0) ? $urandom : {20'h0, pc[11:0] ^ 12'h300};
      ptk  = m_pred(pc);
      ptgt = m_ptgt(pc);
      if ($urandom_range(0, 9) == 0) ptk = !ptk;
      if ($urandom_range(0, 9) == 0) ptgt = $urandom;
      step(0, lk, en, pc, tk, tgt, ptk, ptgt);
    end
  endtask

  initial begin : driver
    model_reset();
    step(1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    for (int k = 0; k < 3; k++) step(0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100);
    for (int k = 0; k < 4; k++) step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(0, 32'h40, 1, 32'h80, 1, 32'h200, 0, 32'h84);
    step(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 32'h0C, 1, 32'h0C, 0, 32'h0, 0, 32'h10);
    step(0, 32'h0C, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(1, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44);
    step(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
    rand_steps(300);
    step(1, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100);
    step(0, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    rand_steps(300);
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (3) @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
